// File: rtl/mem_port_arbiter.sv
// Locked-grant arbiter between RC4 stage controllers and single-port memories.
// The owner drives the memory port combinationally; read data returns through a tagged pipeline.
module mem_port_arbiter #(
  parameter int unsigned NUM_CLIENTS = 3,
  parameter int unsigned NUM_MEMS    = 3,
  parameter int unsigned ADDR_W      = 8,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SEL_W       = 2,
  parameter int unsigned READ_LAT    = 1,
  parameter int unsigned RR_MODE     = 0
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_CLIENTS-1:0]        req,
  output logic [NUM_CLIENTS-1:0]        gnt,
  input  logic [NUM_CLIENTS*SEL_W-1:0]  cl_sel,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_wdata,
  input  logic [NUM_CLIENTS-1:0]        cl_wren,
  input  logic [NUM_CLIENTS-1:0]        cl_rden,
  output logic [NUM_CLIENTS*DATA_W-1:0] cl_rdata,
  output logic [NUM_CLIENTS-1:0]        cl_rvalid,
  output logic [NUM_MEMS*ADDR_W-1:0]    mem_addr,
  output logic [NUM_MEMS*DATA_W-1:0]    mem_wdata,
  output logic [NUM_MEMS-1:0]           mem_wren,
  input  logic [NUM_MEMS*DATA_W-1:0]    mem_q,
  output logic                          sel_err
);

  localparam int unsigned ID_W    = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1;
  localparam int unsigned ROM_IDX = 2;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GRANT = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]        state, state_nxt;
  logic [ID_W-1:0]   owner, rr_ptr, win, idx;
  logic              win_found, load;

  logic [SEL_W-1:0]  sel_a   [NUM_CLIENTS];
  logic [ADDR_W-1:0] addr_a  [NUM_CLIENTS];
  logic [DATA_W-1:0] wdata_a [NUM_CLIENTS];

  for (genvar c = 0; c < NUM_CLIENTS; c++) begin : g_unpack
    assign sel_a[c]   = cl_sel[c*SEL_W +: SEL_W];
    assign addr_a[c]  = cl_addr[c*ADDR_W +: ADDR_W];
    assign wdata_a[c] = cl_wdata[c*DATA_W +: DATA_W];
  end

  logic [SEL_W-1:0]  own_sel;
  logic [ADDR_W-1:0] own_addr;
  logic [DATA_W-1:0] own_wdata;
  logic              own_wren, own_rden, sel_bad, rom_wr, fwd, push, err_set;

  assign own_sel   = sel_a[owner];
  assign own_addr  = addr_a[owner];
  assign own_wdata = wdata_a[owner];
  assign own_wren  = cl_wren[owner];
  assign own_rden  = cl_rden[owner];
  assign sel_bad   = 32'(own_sel) >= NUM_MEMS;
  assign rom_wr    = own_wren && (32'(own_sel) == ROM_IDX);
  assign fwd       = (state == GRANT) && !sel_bad && !rom_wr;
  assign push      = fwd && own_rden;
  assign err_set   = (state == GRANT) && (own_wren || own_rden) && (sel_bad || rom_wr);

  // Winner search: fixed from client 0, or rotating from the pointer.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_CLIENTS; i++) begin
      idx = (RR_MODE != 0) ? ID_W'((32'(rr_ptr) + i) % NUM_CLIENTS) : ID_W'(i);
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win       = idx;
      end
    end
  end

  logic              pipe_v   [READ_LAT];
  logic [ID_W-1:0]   pipe_id  [READ_LAT];
  logic [SEL_W-1:0]  pipe_sel [READ_LAT];
  logic              busy;
  logic [DATA_W-1:0] ret_q;

  always_comb begin
    busy = 1'b0;
    for (int unsigned i = 0; i < READ_LAT; i++) busy = busy | pipe_v[i];
  end

  always_ff @(posedge clk) begin
    state <= reset_n ? state_nxt : IDLE;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          load      = 1'b1;
        end
      end
      GRANT: begin
        if (!req[owner]) state_nxt = (busy || push) ? DRAIN : IDLE;
      end
      DRAIN: begin
        if (!busy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      gnt     <= '0;
      owner   <= '0;
      rr_ptr  <= '0;
      sel_err <= 1'b0;
    end else begin
      if (load) begin
        gnt    <= NUM_CLIENTS'(1) << win;
        owner  <= win;
        rr_ptr <= (32'(win) == NUM_CLIENTS - 1) ? '0 : win + ID_W'(1);
      end else if (state == GRANT && state_nxt != GRANT) begin
        gnt <= '0;
      end
      sel_err <= sel_err | err_set;
    end
  end

  // Only the selected memory sees the owner's access; everything else is parked at zero.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = '0;
    for (int unsigned m = 0; m < NUM_MEMS; m++) begin
      if (fwd && 32'(own_sel) == m) begin
        mem_addr[m*ADDR_W +: ADDR_W]  = own_addr;
        mem_wdata[m*DATA_W +: DATA_W] = own_wdata;
        mem_wren[m]                   = own_wren;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < READ_LAT; i++) begin
        pipe_v[i]   <= 1'b0;
        pipe_id[i]  <= '0;
        pipe_sel[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= push;
      pipe_id[0]  <= owner;
      pipe_sel[0] <= own_sel;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_sel[i] <= pipe_sel[i-1];
      end
    end
  end

  always_comb begin
    ret_q = '0;
    for (int unsigned m = 0; m < NUM_MEMS; m++) begin
      if (32'(pipe_sel[READ_LAT-1]) == m) ret_q = mem_q[m*DATA_W +: DATA_W];
    end
  end

  // Return stage: only the tagged client's data register is updated.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cl_rdata  <= '0;
      cl_rvalid <= '0;
    end else begin
      cl_rvalid <= '0;
      if (pipe_v[READ_LAT-1]) begin
        for (int unsigned c = 0; c < NUM_CLIENTS; c++) begin
          if (32'(pipe_id[READ_LAT-1]) == c) begin
            cl_rvalid[c]                 <= 1'b1;
            cl_rdata[c*DATA_W +: DATA_W] <= ret_q;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one fixed-priority/1-cycle arbiter and one round-robin/3-cycle arbiter
// share the client stimulus; memories return q = addr ^ 0xFF after their latency.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  req;
  logic [5:0]  cl_sel;
  logic [23:0] cl_addr, cl_wdata;
  logic [2:0]  cl_wren, cl_rden;

  logic [2:0]  a_gnt, a_rvalid, a_mwren;
  logic [23:0] a_rdata, a_maddr, a_mwdata, a_q;
  logic        a_err;
  logic [2:0]  b_gnt, b_rvalid, b_mwren;
  logic [23:0] b_rdata, b_maddr, b_mwdata, b_q, b_d1, b_d2;
  logic        b_err;

  int vectors;
  int miscompares;

  always #5 clk = ~clk;

  mem_port_arbiter #(.READ_LAT(1), .RR_MODE(0)) dut_a (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(a_gnt),
    .cl_sel(cl_sel), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_wren(cl_wren), .cl_rden(cl_rden), .cl_rdata(a_rdata), .cl_rvalid(a_rvalid),
    .mem_addr(a_maddr), .mem_wdata(a_mwdata), .mem_wren(a_mwren), .mem_q(a_q),
    .sel_err(a_err)
  );

  mem_port_arbiter #(.READ_LAT(3), .RR_MODE(1)) dut_b (
    .clk(clk), .reset_n(reset_n), .req(req), .gnt(b_gnt),
    .cl_sel(cl_sel), .cl_addr(cl_addr), .cl_wdata(cl_wdata),
    .cl_wren(cl_wren), .cl_rden(cl_rden), .cl_rdata(b_rdata), .cl_rvalid(b_rvalid),
    .mem_addr(b_maddr), .mem_wdata(b_mwdata), .mem_wren(b_mwren), .mem_q(b_q),
    .sel_err(b_err)
  );

  // Memory models: synchronous read, q = addr ^ 0xFF
  always @(posedge clk) begin
    a_q  <= a_maddr ^ 24'hFFFFFF;
    b_d1 <= b_maddr;
    b_d2 <= b_d1;
    b_q  <= b_d2 ^ 24'hFFFFFF;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_all();
    cl_sel   = '0;
    cl_addr  = '0;
    cl_wdata = '0;
    cl_wren  = '0;
    cl_rden  = '0;
  endtask

  task automatic drive(input int c, input logic [1:0] sel, input logic [7:0] addr,
                       input logic [7:0] wd, input logic wr, input logic rd);
    idle_all();
    cl_sel[c*2 +: 2]   = sel;
    cl_addr[c*8 +: 8]  = addr;
    cl_wdata[c*8 +: 8] = wd;
    cl_wren[c]         = wr;
    cl_rden[c]         = rd;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    req     = '0;
    idle_all();
    step();
    step();
    reset_n = 1'b1;
  endtask

  logic [7:0] rd_exp [4] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
  logic [2:0] rr_exp [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
  int         rr_id  [4] = '{0, 1, 2, 0};

  initial begin
    vectors     = 0;
    miscompares = 0;

    // reset state
    do_reset();
    settle();
    chk("rst_gnt",    32'(a_gnt), 32'h0);
    chk("rst_rvalid", 32'(a_rvalid), 32'h0);
    chk("rst_err",    32'(a_err), 32'h0);
    chk("rst_mwren",  32'(a_mwren), 32'h0);
    chk("rst_maddr",  32'(a_maddr), 32'h0);

    // grant latency and single write
    req = 3'b001;
    settle();
    chk("gnt_wait", 32'(a_gnt), 32'h0);
    step();
    chk("gnt_c0", 32'(a_gnt), 32'h1);
    drive(0, 2'd0, 8'h10, 8'hA5, 1'b1, 1'b0);
    settle();
    chk("wr_mwren",  32'(a_mwren), 32'h1);
    chk("wr_maddr",  32'(a_maddr), 32'h10);
    chk("wr_mwdata", 32'(a_mwdata), 32'hA5);

    // back-to-back reads
    for (int k = 0; k < 7; k++) begin
      step();
      if (k < 4) drive(0, 2'd0, 8'(k), 8'h00, 1'b0, 1'b1);
      else idle_all();
      settle();
      chk("rd_valid", 32'(a_rvalid), (k >= 2 && k < 6) ? 32'h1 : 32'h0);
      if (k >= 2 && k < 6) chk("rd_data", 32'(a_rdata[7:0]), 32'(rd_exp[k-2]));
    end
    req = '0;

    // fixed priority with one idle cycle between owners
    do_reset();
    req = 3'b110;
    step();
    chk("fp_gnt1", 32'(a_gnt), 32'h2);
    req = 3'b100;
    step();
    chk("fp_gap", 32'(a_gnt), 32'h0);
    step();
    chk("fp_gnt2", 32'(a_gnt), 32'h4);

    // round robin order 0,1,2,0
    do_reset();
    req = 3'b111;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_gnt", 32'(b_gnt), 32'(rr_exp[k]));
      drive(rr_id[k], 2'd0, 8'(k), 8'h5A, 1'b1, 1'b0);
      settle();
      chk("rr_wr", 32'(b_mwren), 32'h1);
      step();
      idle_all();
      req = 3'b111 & ~rr_exp[k];
      step();
      chk("rr_gap", 32'(b_gnt), 32'h0);
      req = 3'b111;
    end

    // owner releases with a read in flight (3-cycle latency)
    do_reset();
    req = 3'b001;
    step();
    chk("dr_gnt0", 32'(b_gnt), 32'h1);
    drive(0, 2'd0, 8'h22, 8'h00, 1'b0, 1'b1);
    step();
    idle_all();
    req = 3'b010;
    for (int k = 1; k < 8; k++) begin
      if (k > 1) step();
      settle();
      chk("dr_rvalid", 32'(b_rvalid), (k == 4) ? 32'h1 : 32'h0);
      chk("dr_gnt", 32'(b_gnt), (k == 1) ? 32'h1 : ((k >= 6) ? 32'h2 : 32'h0));
      if (k == 4) chk("dr_data", 32'(b_rdata[7:0]), 32'hDD);
    end
    req = '0;

    // ROM write and out-of-range select are dropped and flagged
    do_reset();
    req = 3'b100;
    step();
    chk("rom_gnt", 32'(a_gnt), 32'h4);
    drive(2, 2'd2, 8'h05, 8'h77, 1'b1, 1'b0);
    settle();
    chk("rom_mwren", 32'(a_mwren), 32'h0);
    chk("rom_maddr", 32'(a_maddr), 32'h0);
    chk("rom_err0",  32'(a_err), 32'h0);
    step();
    idle_all();
    settle();
    chk("rom_err1", 32'(a_err), 32'h1);
    drive(2, 2'd3, 8'h01, 8'h00, 1'b0, 1'b1);
    settle();
    chk("bad_maddr", 32'(a_maddr), 32'h0);
    step();
    idle_all();
    step();
    chk("bad_rvalid", 32'(a_rvalid), 32'h0);
    chk("err_sticky", 32'(a_err), 32'h1);

    // reset mid-read discards the return
    drive(2, 2'd1, 8'h09, 8'h00, 1'b0, 1'b1);
    step();
    idle_all();
    reset_n = 1'b0;
    step();
    chk("mr_rvalid", 32'(a_rvalid), 32'h0);
    chk("mr_gnt",    32'(a_gnt), 32'h0);
    chk("mr_err",    32'(a_err), 32'h0);
    chk("mr_rdata",  32'(a_rdata), 32'h0);
    req     = '0;
    reset_n = 1'b1;
    step();
    chk("mr_rvalid2", 32'(a_rvalid), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
